// File: rtl/testing_sram.sv
// 128-bit wide word SRAM with byte addressing, single-cycle reads and a
// bank dump mode that streams half (by default) of the array out of valueOut.
module testing_sram #(
  parameter int DEPTH_WORDS = 64,
  parameter int DUMP_WORDS  = DEPTH_WORDS / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read,
  input  logic         write,
  input  logic [15:0]  addr,
  input  logic [127:0] valueIn,
  input  logic         dump,
  input  logic         dumpNum,
  output logic [127:0] valueOut,
  output logic         dump_valid,
  output logic         dump_busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [15:0]   IDX_MASK   = 16'((DEPTH_WORDS - 1) << 4);
  localparam logic [AW-1:0] BANK1_BASE = AW'(DUMP_WORDS);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DUMP_WORDS - 1);

  typedef enum logic {
    IDLE,
    DUMPING
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [127:0]  r_mem [DEPTH_WORDS];
  logic [CW-1:0] r_dumpCnt;
  logic          r_bank;

  logic [AW-1:0] w_wordIdx;
  logic [AW-1:0] w_dumpIdx;
  logic          w_dumpStart;
  logic          w_dumpStep;
  logic          w_doWrite;
  logic          w_doRead;
  logic          w_unusedAddrBits;

  // Byte offset and bits above the word index are don't-cares, so addresses wrap.
  assign w_wordIdx        = addr[AW+3:4];
  assign w_unusedAddrBits = ^(addr & ~IDX_MASK);
  assign w_dumpIdx        = (r_bank ? BANK1_BASE : '0) + AW'(r_dumpCnt);
  assign dump_busy        = (r_state == DUMPING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Dump start outranks write, and write outranks read; everything is ignored while dumping.
  always_comb begin
    w_nextState = r_state;
    w_dumpStart = 1'b0;
    w_dumpStep  = 1'b0;
    w_doWrite   = 1'b0;
    w_doRead    = 1'b0;
    case (r_state)
      IDLE: begin
        if (dump) begin
          w_dumpStart = 1'b1;
          w_nextState = DUMPING;
        end else if (write) begin
          w_doWrite = 1'b1;
        end else if (read) begin
          w_doRead = 1'b1;
        end
      end
      DUMPING: begin
        w_dumpStep = 1'b1;
        if (r_dumpCnt == LAST_CNT) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dumpCnt <= '0;
      r_bank    <= 1'b0;
    end else if (w_dumpStart) begin
      r_dumpCnt <= '0;
      r_bank    <= dumpNum;
    end else if (w_dumpStep) begin
      r_dumpCnt <= r_dumpCnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valueOut   <= '0;
      dump_valid <= 1'b0;
    end else begin
      dump_valid <= w_dumpStep;
      if (w_dumpStep) begin
        valueOut <= r_mem[w_dumpIdx];
      end else if (w_doRead) begin
        valueOut <= r_mem[w_wordIdx];
      end
    end
  end

  // Storage is flops rather than a macro because reset must clear every word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_doWrite) begin
      r_mem[w_wordIdx] <= valueIn;
    end
  end

endmodule

// File: tb/tb_testing_sram.sv
// Scoreboard bench for testing_sram: a reference memory produces expected
// words that are queued when a read or dump is issued and popped on output.
module tb_testing_sram;

  localparam int DEPTH = 64;
  localparam int DUMPW = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         read;
  logic         write;
  logic [15:0]  addr;
  logic [127:0] valueIn;
  logic         dump;
  logic         dumpNum;
  logic [127:0] valueOut;
  logic         dumpValid;
  logic         dumpBusy;

  int           compareCount  = 0;
  int           mismatchCount = 0;
  logic [127:0] expQ [$];
  logic [127:0] model [DEPTH];
  logic [127:0] lastOut = '0;

  always #5 clk = ~clk;

  testing_sram #(
    .DEPTH_WORDS(DEPTH),
    .DUMP_WORDS (DUMPW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .valueIn   (valueIn),
    .dump      (dump),
    .dumpNum   (dumpNum),
    .valueOut  (valueOut),
    .dump_valid(dumpValid),
    .dump_busy (dumpBusy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                               input logic [127:0] v, input logic dp, input logic dn);
    read    = rd;
    write   = wr;
    addr    = a;
    valueIn = v;
    dump    = dp;
    dumpNum = dn;
  endtask

  function automatic int idxOf(input logic [15:0] a);
    return int'(a[9:4]);
  endfunction

  task automatic popCheck(input string tag);
    logic [127:0] e;
    e = expQ.pop_front();
    checkOutput(tag, valueOut, e);
    lastOut = e;
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [127:0] v);
    applyStimulus(1'b0, 1'b1, a, v, 1'b0, 1'b0);
    tick();
    model[idxOf(a)] = v;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [15:0] a);
    applyStimulus(1'b1, 1'b0, a, '0, 1'b0, 1'b0);
    expQ.push_back(model[idxOf(a)]);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0);
    popCheck(tag);
  endtask

  // A write is attempted in the first dump cycle; it must not reach memory.
  task automatic runDump(input logic bank, input logic hold, input string tag);
    int busyCycles;
    busyCycles = 0;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, 1'b1, bank);
    for (int i = 0; i < DUMPW; i++) begin
      expQ.push_back(model[(int'(bank) * DUMPW + i) % DEPTH]);
    end
    tick();
    checkOutput({tag, "_startValid"}, 128'(dumpValid), 128'd0);
    applyStimulus(1'b0, 1'b1, 16'h0030, {4{32'hDEADBEEF}}, hold, ~bank);
    for (int c = 0; c < DUMPW + 8 && expQ.size() > 0; c++) begin
      if (dumpBusy) busyCycles++;
      tick();
      applyStimulus(1'b0, 1'b0, 16'h0, '0, hold, ~bank);
      if (dumpValid) popCheck({tag, "_word"});
    end
    checkOutput({tag, "_leftover"}, 128'(expQ.size()), 128'd0);
    expQ.delete();
    checkOutput({tag, "_busyCycles"}, 128'(busyCycles), 128'(DUMPW));
    checkOutput({tag, "_busyAfterLast"}, 128'(dumpBusy), 128'd0);
    tick();
    checkOutput({tag, "_validAfterLast"}, 128'(dumpValid), 128'd0);
    checkOutput({tag, "_restartBusy"}, 128'(dumpBusy), 128'(hold));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("resetValueOut", valueOut, 128'd0);
    checkOutput("resetDumpValid", 128'(dumpValid), 128'd0);
    checkOutput("resetDumpBusy", 128'(dumpBusy), 128'd0);
    rst = 1'b0;

    doWrite(16'h0000, 128'h0123456789ABCDEFFEDCBA9876543210);
    doWrite(16'h0010, {128{1'b1}});
    doWrite(16'h0020, 128'hAABBCCDDEEFF00998877665544332211);
    doRead("read0", 16'h0000);
    doRead("read16", 16'h0010);
    doRead("read32", 16'h0020);

    applyStimulus(1'b0, 1'b0, 16'h0020, 128'h5, 1'b0, 1'b0);
    tick();
    checkOutput("idleHold", valueOut, lastOut);

    doRead("unaligned25", 16'h0025);
    doRead("wrap", 16'(16 * DEPTH + 32));

    applyStimulus(1'b1, 1'b1, 16'h0010, '0, 1'b0, 1'b0);
    tick();
    model[1] = '0;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0);
    checkOutput("collisionHold", valueOut, lastOut);
    doRead("collisionRead", 16'h0010);

    doWrite(16'h0010, {128{1'b1}});
    doWrite(16'h0210, 128'hCAFEF00D_0000_1111_2222_3333_4444_5555);

    runDump(1'b0, 1'b0, "dump0");
    doRead("dumpWriteIgnored", 16'h0030);

    runDump(1'b1, 1'b1, "dump1");
    tick();
    tick();
    #2;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    checkOutput("midDumpResetValue", valueOut, 128'd0);
    checkOutput("midDumpResetValid", 128'(dumpValid), 128'd0);
    checkOutput("midDumpResetBusy", 128'(dumpBusy), 128'd0);
    tick();
    rst = 1'b0;
    doRead("postResetRead0", 16'h0000);
    doRead("postResetRead33", 16'h0210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
